// File: rtl/pipe_ctrl_if.sv
// Pipeline-control signal bundle.
// Carries the hazard/stall requests and HALT/resume controls into pipe_ctrl, and the per-stage
// hold vector, halted/timeout status and stall-cycle counter back out.
//   master : pipeline side (drives requests, observes stall/status)
//   slave  : pipe_ctrl side (observes requests, drives stall/status)
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        ex_is_load;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic        id_reg1_read;
  logic        id_reg2_read;
  logic [4:0]  id_reg1_addr;
  logic [4:0]  id_reg2_addr;
  logic        halt_i;
  logic        resume_i;
  logic [5:0]  stall_o;
  logic        halted_o;
  logic        timeout_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output stallreq_id, stallreq_ex, ex_is_load, ex_wreg, ex_wd,
           id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr, halt_i, resume_i,
    input  stall_o, halted_o, timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, ex_is_load, ex_wreg, ex_wd,
           id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr, halt_i, resume_i,
    output stall_o, halted_o, timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall / halt controller.
// Generates the per-stage hold vector (bit0 PC .. bit5 WB) from load-use hazards, ID/EX stall
// requests and a RUN -> DRAIN -> HALTED state machine, plus an EX-stall watchdog.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : pipe_ctrl_if.slave (stall requests, hazard operands, halt/resume in;
//          stall_o, halted_o, timeout_o, stall_cycles_o out)
// Optional feature: define PIPE_PERF_CNT_EN to build the 32-bit stall-cycle counter;
// otherwise stall_cycles_o is tied to zero and no counter flops exist.
module pipe_ctrl (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e      state_q;
  logic [1:0]  drain_cnt_q;
  logic        halted_q;
  logic [5:0]  wd_cnt_q;
  logic [5:0]  wd_cnt_d;
  logic        timeout_q;
  logic        load_use;
  logic [5:0]  stall;

  // Consumer in ID needs a register the load in EX has not produced yet.
  always_comb begin
    load_use = bus.ex_is_load && bus.ex_wreg && (bus.ex_wd != 5'd0) &&
               ((bus.id_reg1_read && (bus.id_reg1_addr == bus.ex_wd)) ||
                (bus.id_reg2_read && (bus.id_reg2_addr == bus.ex_wd)));
  end

  // Purely combinational so a hazard holds the pipe in the very cycle it appears.
  always_comb begin
    stall = 6'b000000;
    if (rst) begin
      stall = 6'b000000;
    end else if (state_q == StHalted) begin
      stall = 6'b111111;
    end else if (bus.stallreq_ex) begin
      stall = 6'b001111;
    end else if (load_use || bus.stallreq_id) begin
      stall = 6'b000111;
    end else if (state_q == StDrain) begin
      stall = 6'b000011;
    end
  end

  assign bus.stall_o  = stall;
  assign bus.halted_o = halted_q;

  // HALT is only accepted when ID/EX are not held, so a stalled HALT naturally retries.
  // DRAIN lets the in-flight instructions retire; an EX stall freezes the countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.halt_i && !stall[2]) begin
            state_q     <= StDrain;
            drain_cnt_q <= 2'd3;
          end
        end
        StDrain: begin
          if (!bus.stallreq_ex) begin
            if (drain_cnt_q == 2'd0) begin
              state_q  <= StHalted;
              halted_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - 2'd1;
            end
          end
        end
        StHalted: begin
          if (bus.resume_i) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StRun;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog counts consecutive EX-stall cycles and saturates at 63.
  always_comb begin
    if (!bus.stallreq_ex) begin
      wd_cnt_d = 6'd0;
    end else if (wd_cnt_q == 6'd63) begin
      wd_cnt_d = 6'd63;
    end else begin
      wd_cnt_d = wd_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d == 6'd63) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else if (stall[0] && (state_q != StHalted)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_cycles_o = stall_cycles_q;
`else
  assign bus.stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: mode plus "cycles of draining still owed", a run length of EX stalls,
  // and a plain stall-cycle tally.
  typedef enum int {MRun, MDrain, MHalted} mode_e;

  mode_e       mode;
  int          drain_left;
  int          ex_run;
  bit          m_timeout;
  logic [31:0] m_perf;
  bit          model_valid;

  int vectors;
  int miscompares;

  function automatic logic [5:0] exp_stall();
    bit hz;
    hz = bus.ex_is_load && bus.ex_wreg && (bus.ex_wd != 0) &&
         ((bus.id_reg1_read && (bus.id_reg1_addr == bus.ex_wd)) ||
          (bus.id_reg2_read && (bus.id_reg2_addr == bus.ex_wd)));
    if (rst) return 6'h00;
    if (mode == MHalted) return 6'h3f;
    if (bus.stallreq_ex) return 6'h0f;
    if (hz || bus.stallreq_id) return 6'h07;
    if (mode == MDrain) return 6'h03;
    return 6'h00;
  endfunction

  task automatic clear_inputs();
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.ex_is_load   = 1'b0;
    bus.ex_wreg      = 1'b0;
    bus.ex_wd        = 5'd0;
    bus.id_reg1_read = 1'b0;
    bus.id_reg2_read = 1'b0;
    bus.id_reg1_addr = 5'd0;
    bus.id_reg2_addr = 5'd0;
    bus.halt_i       = 1'b0;
    bus.resume_i     = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.stallreq_id  = ($urandom_range(0, 5) == 0);
    bus.stallreq_ex  = ($urandom_range(0, 4) == 0);
    bus.ex_is_load   = $urandom_range(0, 1) == 1;
    bus.ex_wreg      = $urandom_range(0, 3) != 0;
    bus.ex_wd        = 5'($urandom_range(0, 3));
    bus.id_reg1_read = $urandom_range(0, 1) == 1;
    bus.id_reg2_read = $urandom_range(0, 1) == 1;
    bus.id_reg1_addr = 5'($urandom_range(0, 3));
    bus.id_reg2_addr = 5'($urandom_range(0, 3));
    bus.halt_i       = ($urandom_range(0, 7) == 0);
    bus.resume_i     = ($urandom_range(0, 5) == 0);
  endtask

  task automatic check(input string tag);
    logic [5:0]  es;
    logic [31:0] ep;
    es = exp_stall();
    vectors++;
    assert (bus.stall_o === es) else begin
      miscompares++;
      $error("FAIL %s stall_o got %b expected %b", tag, bus.stall_o, es);
    end
    if (model_valid) begin
`ifdef PIPE_PERF_CNT_EN
      ep = m_perf;
`else
      ep = 32'h0;
`endif
      vectors++;
      assert (bus.halted_o === (mode == MHalted)) else begin
        miscompares++;
        $error("FAIL %s halted_o got %b expected %b", tag, bus.halted_o, mode == MHalted);
      end
      vectors++;
      assert (bus.timeout_o === m_timeout) else begin
        miscompares++;
        $error("FAIL %s timeout_o got %b expected %b", tag, bus.timeout_o, m_timeout);
      end
      vectors++;
      assert (bus.stall_cycles_o === ep) else begin
        miscompares++;
        $error("FAIL %s stall_cycles_o got %0d expected %0d", tag, bus.stall_cycles_o, ep);
      end
    end
  endtask

  task automatic update();
    logic [5:0] s;
    s = exp_stall();
    if (rst) begin
      mode        = MRun;
      drain_left  = 0;
      ex_run      = 0;
      m_timeout   = 1'b0;
      m_perf      = 32'd0;
      model_valid = 1'b1;
    end else begin
      if (s[0] && mode != MHalted) m_perf = m_perf + 32'd1;
      if (bus.stallreq_ex) begin
        ex_run = (ex_run < 63) ? ex_run + 1 : 63;
        if (ex_run == 63) m_timeout = 1'b1;
      end else begin
        ex_run = 0;
      end
      case (mode)
        MRun: if (bus.halt_i && !s[2]) begin
          mode       = MDrain;
          drain_left = 4;
        end
        MDrain: if (!bus.stallreq_ex) begin
          drain_left--;
          if (drain_left == 0) mode = MHalted;
        end
        default: if (bus.resume_i) mode = MRun;
      endcase
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic cycle_lit(input string tag, input logic [5:0] lit);
    @(negedge clk);
    check(tag);
    vectors++;
    assert (bus.stall_o === lit) else begin
      miscompares++;
      $error("FAIL %s_lit stall_o got %b expected %b", tag, bus.stall_o, lit);
    end
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_valid = 1'b0;
    mode        = MRun;
    drain_left  = 0;
    ex_run      = 0;
    m_timeout   = 1'b0;
    m_perf      = 32'd0;
    clear_inputs();
    rst = 1'b1;

    // Reset holds stall_o at zero whatever the inputs are.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cycle_lit("rst_hold", 6'h00);
    end
    rst = 1'b0;
    clear_inputs();
    cycle_lit("idle", 6'h00);

    // Load-use through port 2, then cleared.
    bus.ex_is_load = 1'b1; bus.ex_wreg = 1'b1; bus.ex_wd = 5'd5;
    bus.id_reg2_read = 1'b1; bus.id_reg2_addr = 5'd5;
    cycle_lit("load_use2", 6'h07);
    bus.ex_is_load = 1'b0;
    cycle_lit("load_gone", 6'h00);
    bus.ex_is_load = 1'b1; bus.ex_wd = 5'd0; bus.id_reg2_addr = 5'd0;
    cycle_lit("wd_zero", 6'h00);
    clear_inputs();
    bus.ex_is_load = 1'b1; bus.ex_wreg = 1'b1; bus.ex_wd = 5'd9;
    bus.id_reg1_read = 1'b1; bus.id_reg1_addr = 5'd9;
    cycle_lit("load_use1", 6'h07);
    bus.id_reg1_read = 1'b0;
    cycle_lit("no_read", 6'h00);
    clear_inputs();

    // EX stall outranks ID stall.
    bus.stallreq_ex = 1'b1; bus.stallreq_id = 1'b1;
    cycle_lit("ex_and_id", 6'h0f);
    clear_inputs();

    // Halt, drain four cycles, halted, resume.
    bus.halt_i = 1'b1;
    cycle_lit("halt_req", 6'h00);
    bus.halt_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle_lit("drain", 6'h03);
    cycle_lit("halted", 6'h3f);
    bus.halt_i = 1'b1;
    cycle_lit("halt_ignored", 6'h3f);
    bus.halt_i = 1'b0;
    bus.resume_i = 1'b1;
    cycle_lit("resume", 6'h3f);
    bus.resume_i = 1'b0;
    cycle_lit("running", 6'h00);

    // Halt deferred behind an ID stall.
    bus.halt_i = 1'b1; bus.stallreq_id = 1'b1;
    cycle_lit("halt_defer", 6'h07);
    cycle_lit("halt_defer", 6'h07);
    bus.halt_i = 1'b0; bus.stallreq_id = 1'b0;
    cycle_lit("not_draining", 6'h00);

    // EX stall freezes the drain countdown.
    bus.halt_i = 1'b1;
    cycle_lit("halt_req2", 6'h00);
    bus.halt_i = 1'b0;
    cycle_lit("drain2", 6'h03);
    bus.stallreq_ex = 1'b1;
    cycle_lit("drain_ex", 6'h0f);
    cycle_lit("drain_ex", 6'h0f);
    bus.stallreq_ex = 1'b0;
    for (int i = 0; i < 3; i++) cycle_lit("drain2", 6'h03);
    cycle_lit("halted2", 6'h3f);

    // Reset while halted, then while draining.
    rst = 1'b1;
    cycle_lit("rst_halted", 6'h00);
    rst = 1'b0;
    cycle_lit("after_rst", 6'h00);
    bus.halt_i = 1'b1;
    cycle_lit("halt_req3", 6'h00);
    bus.halt_i = 1'b0;
    cycle_lit("drain3", 6'h03);
    rst = 1'b1;
    cycle_lit("rst_drain", 6'h00);
    rst = 1'b0;
    cycle_lit("after_rst2", 6'h00);

    // Watchdog: 70 cycles of EX stall, flag rises on the 64th and sticks.
    bus.stallreq_ex = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      check("wd_hold");
      vectors++;
      assert (bus.timeout_o === (i >= 64)) else begin
        miscompares++;
        $error("FAIL wd_cycle%0d timeout_o got %b expected %b", i, bus.timeout_o, i >= 64);
      end
      @(posedge clk);
      update();
      #1;
    end
    bus.stallreq_ex = 1'b0;
    for (int i = 0; i < 5; i++) cycle("wd_sticky");
    rst = 1'b1;
    cycle("wd_rst");
    rst = 1'b0;
    cycle("wd_cleared");

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 99) == 0);
      cycle("random");
    end
    rst = 1'b0;
    clear_inputs();
    cycle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: stallreq_id  in  1  ID-stage stall request.
REQ-004 SHALL provide: stallreq_ex  in  1  EX-stage multi-cycle stall request (level, held until done).
REQ-005 SHALL provide: ex_is_load  in  1  instruction in EX is LW.
REQ-006 SHALL provide: ex_wreg  in  1  EX-stage instruction writes a register.
REQ-007 SHALL provide: ex_wd  in  5  EX-stage destination register.
REQ-008 SHALL provide: id_reg1_read, id_reg2_read  in  1 each  ID read enables.
REQ-009 SHALL provide: id_reg1_addr, id_reg2_addr  in  5 each  ID source addresses.
REQ-010 SHALL provide: halt_i  in  1  HALT decoded in ID.
REQ-011 SHALL provide: resume_i  in  1  external restart pulse.
REQ-012 SHALL provide: stall_o  out  6  per-stage hold: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
REQ-013 SHALL provide: halted_o  out  1  core halted.
REQ-014 SHALL provide: timeout_o  out  1  sticky EX-stall watchdog flag.
REQ-015 SHALL provide: stall_cycles_o  out  32  stall-cycle counter (PIPE_PERF_CNT_EN only).

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-017 Load-use hazard SHALL be: ex_is_load & ex_wreg & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)); combinational, same cycle.
REQ-018 stall_o priority, highest first: HALTED -> 6'b111111; stallreq_ex -> 6'b001111; load-use or stallreq_id -> 6'b000111; DRAIN -> 6'b000011; else 6'b000000.
REQ-019 RUN -> DRAIN when halt_i=1 and stall_o[2]=0 in that cycle; drain counter loads 3.
REQ-020 DRAIN: counter decrements each cycle where stallreq_ex=0; at count 0 with stallreq_ex=0 -> HALTED next cycle.
REQ-021 halt_i ignored outside RUN; halt_i with a concurrent ID/EX stall SHALL defer until the stall clears.
REQ-022 HALTED -> RUN on resume_i=1; resume_i in RUN/DRAIN ignored.
REQ-023 halted_o SHALL equal (state==HALTED), registered.
REQ-024 Watchdog: 6-bit counter increments each cycle stallreq_ex=1, clears when 0; reaching 63 sets timeout_o, which stays set until rst; counter saturates.
REQ-025 stall_o SHALL be combinational from state and inputs; zero added latency.

Reset
REQ-026 On rst=1 at a clock edge: state RUN, drain counter 0, watchdog 0, timeout_o 0, halted_o 0, stall_cycles_o 0.
REQ-027 While rst=1, stall_o SHALL be 6'b000000 regardless of inputs.
REQ-028 rst during DRAIN or HALTED SHALL abort to RUN with no residual stall.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined: stall_cycles_o increments (wrapping at 2^32) every cycle stall_o[0]=1 and state!=HALTED.
REQ-030 PIPE_PERF_CNT_EN undefined: no counter flops; stall_cycles_o tied to 32'h0.

Verification
REQ-031 ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 -> stall_o=6'b000111 that cycle; next cycle ex_is_load=0 -> 6'b000000.
REQ-032 Same as REQ-031 but ex_wd=0 -> stall_o=6'b000000.
REQ-033 stallreq_ex=1 and stallreq_id=1 together -> stall_o=6'b001111.
REQ-034 halt_i pulse in RUN, no other stalls -> 4 cycles stall_o=6'b000011, then halted_o=1, stall_o=6'b111111; resume_i pulse -> RUN, stall_o=0.
REQ-035 stallreq_ex held 70 cycles -> timeout_o rises on the 64th cycle, remains 1 after release until rst.
REQ-036 rst asserted in HALTED -> next cycle halted_o=0, stall_o=0, stall_cycles_o=0.
